// File: rtl/seq_detector_param.sv
// ============================================================================
// Module  : seq_detector_param
// Purpose : Runtime-loadable serial pattern detector with a registered match pulse.
//           Optional saturating match counter, enabled by the macro SEQ_DET_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a,
    input  logic               a_valid,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               match,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;

    logic [MAX_LEN-1:0] w_hist_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_hit;

    assign w_hist_shift = {hist_q[MAX_LEN-2:0], a};
    // Only the low len_q bits take part in the comparison.
    assign w_mask       = ~({MAX_LEN{1'b1}} << len_q);
    assign w_hit        = (((w_hist_shift ^ pat_q) & w_mask) == '0);
    assign w_fill_inc   = (fill_q < len_q) ? fill_q + 1'b1 : fill_q;
    assign w_len_clamp  = (pat_len > C_MAX_LEN) ? C_MAX_LEN : pat_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hist_q  <= '0;
            pat_q   <= '0;
            fill_q  <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;
        if (pat_load) begin
            pat_d   = pat_in;
            ovl_d   = overlap;
            len_d   = w_len_clamp;
            hist_d  = '0;
            fill_d  = '0;
            state_d = (w_len_clamp == '0) ? S_IDLE : S_FILL;
        end else if (a_valid && (state_q != S_IDLE)) begin
            hist_d = w_hist_shift;
            fill_d = w_fill_inc;
            // The sample that completes the window is compared, whether arriving in FILL or ARMED.
            if (w_fill_inc == len_q) begin
                state_d = S_ARMED;
                if (w_hit) begin
                    match_d = 1'b1;
                    if (!ovl_q) begin
                        fill_d  = '0;
                        state_d = S_FILL;
                    end
                end
            end
        end
    end

    assign match = match_q;
    assign armed = (state_q == S_ARMED);

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (pat_load) begin
            cnt_q <= '0;
        end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module  : tb_seq_detector_param
// Purpose : Directed self-checking bench for seq_detector_param (MAX_LEN=8, CNT_W=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               a;
    logic               a_valid;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               match;
    logic               armed;
    logic [CNT_W-1:0]   match_cnt;

    int vectors = 0;
    int errors  = 0;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .a_valid   (a_valid),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .match     (match),
        .armed     (armed),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cexp(input int n);
`ifdef SEQ_DET_CNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic bit_v, input logic valid);
        @(negedge clk);
        a        = bit_v;
        a_valid  = valid;
        pat_load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic bit_v, input logic valid);
        @(negedge clk);
        pat_in   = p;
        pat_len  = len;
        overlap  = ovl;
        pat_load = 1'b1;
        a        = bit_v;
        a_valid  = valid;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        a        = 1'b0;
        a_valid  = 1'b0;
        pat_load = 1'b0;
        pat_in   = '0;
        pat_len  = '0;
        overlap  = 1'b0;
        #12;
        check("rst_match", 32'(match), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Legacy "0 then 1"
        load(8'b01, 4'd2, 1'b1, 1'b0, 1'b0);
        check("t1_armed_after_load", 32'(armed), 32'd0);
        send(1'b0, 1'b1); check("t1_s1", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t1_s2", 32'(match), 32'd1);
        check("t1_armed", 32'(armed), 32'd1);
        send(1'b1, 1'b1); check("t1_s3", 32'(match), 32'd0);
        send(1'b0, 1'b1); check("t1_s4", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t1_s5", 32'(match), 32'd1);
        send(1'b0, 1'b0); check("t1_idle_cycle", 32'(match), 32'd0);

        // Overlap mode, 101
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        check("t2_cnt_cleared", 32'(match_cnt), 32'd0);
        send(1'b1, 1'b1); check("t2_s1", 32'(match), 32'd0);
        send(1'b0, 1'b1); check("t2_s2", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t2_s3", 32'(match), 32'd1);
        send(1'b0, 1'b1); check("t2_s4", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t2_s5", 32'(match), 32'd1);
        check("t2_cnt", 32'(match_cnt), cexp(2));

        // Non-overlap mode, 101
        load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1); check("t3_s1", 32'(match), 32'd0);
        send(1'b0, 1'b1); check("t3_s2", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t3_s3", 32'(match), 32'd1);
        check("t3_armed_after_hit", 32'(armed), 32'd0);
        send(1'b0, 1'b1); check("t3_s4", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t3_s5", 32'(match), 32'd0);
        check("t3_armed_end", 32'(armed), 32'd0);

        // Qualifier: middle sample dropped
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1); check("t4a_s1", 32'(match), 32'd0);
        send(1'b0, 1'b0); check("t4a_gap", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t4a_s3", 32'(match), 32'd0);

        // Load priority: the simultaneous a=1 must not enter history
        load(8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b1); check("t4b_s1", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t4b_s2", 32'(match), 32'd0);
        check("t4b_armed", 32'(armed), 32'd0);
        send(1'b0, 1'b1); check("t4b_s3", 32'(match), 32'd0);
        send(1'b1, 1'b1); check("t4b_s4", 32'(match), 32'd1);

        // Zero length stays idle
        load(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b1);
            check("t5a_match", 32'(match), 32'd0);
            check("t5a_armed", 32'(armed), 32'd0);
        end

        // Length clamps to MAX_LEN
        load(8'hFF, 4'd11, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < MAX_LEN; i++) begin
            send(1'b1, 1'b1);
            check("t5b_prefill", 32'(match), 32'd0);
        end
        send(1'b1, 1'b1); check("t5b_full", 32'(match), 32'd1);
        check("t5b_armed", 32'(armed), 32'd1);
        send(1'b1, 1'b1); check("t5b_overlap", 32'(match), 32'd1);
        check("t5b_cnt", 32'(match_cnt), cexp(2));

        // Asynchronous reset while armed and matching
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_match", 32'(match), 32'd0);
        check("t6_rst_armed", 32'(armed), 32'd0);
        check("t6_rst_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send(1'b1, 1'b1); check("t6_no_pattern", 32'(match), 32'd0);
        check("t6_no_pattern_armed", 32'(armed), 32'd0);

        // Counter saturation with a one-bit pattern
        load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1); check("t7_m1", 32'(match), 32'd1); check("t7_c1", 32'(match_cnt), cexp(1));
        send(1'b1, 1'b1); check("t7_m2", 32'(match), 32'd1); check("t7_c2", 32'(match_cnt), cexp(2));
        send(1'b1, 1'b1); check("t7_m3", 32'(match), 32'd1); check("t7_c3", 32'(match_cnt), cexp(3));
        send(1'b1, 1'b1); check("t7_m4", 32'(match), 32'd1); check("t7_c4", 32'(match_cnt), cexp(3));
        send(1'b1, 1'b1); check("t7_m5", 32'(match), 32'd1); check("t7_c5", 32'(match_cnt), cexp(3));
        send(1'b0, 1'b1); check("t7_zero", 32'(match), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
